// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the two-initiator memory arbiter
package mem_arbiter_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        arb_idle,
        arb_serve_i,
        arb_serve_d
    } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - initiator-side and physical-memory-side signals of the arbiter
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic          mem1_read;
    lc3b_word      mem1_address;
    lc3b_word      mem1_rdata;
    logic          mem1_resp;

    logic          mem2_read;
    logic          mem2_write;
    lc3b_mem_wmask mem2_wmask;
    lc3b_word      mem2_address;
    lc3b_word      mem2_wdata;
    lc3b_word      mem2_rdata;
    logic          mem2_resp;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_mem_wmask pmem_wmask;
    lc3b_word      pmem_address;
    lc3b_word      pmem_wdata;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    // Arbiter view: responder to the pipeline, initiator toward memory.
    modport slave (
        input  mem1_read, mem1_address,
        output mem1_rdata, mem1_resp,
        input  mem2_read, mem2_write, mem2_wmask, mem2_address, mem2_wdata,
        output mem2_rdata, mem2_resp,
        output pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    // Environment view: pipeline initiators plus physical memory.
    modport master (
        output mem1_read, mem1_address,
        input  mem1_rdata, mem1_resp,
        output mem2_read, mem2_write, mem2_wmask, mem2_address, mem2_wdata,
        input  mem2_rdata, mem2_resp,
        input  pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes fetch (mem1) and data (mem2) requests onto one physical memory port
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    lc3b_arb_state state;
    logic          last_d;
    logic          read_q;
    logic          write_q;
    lc3b_word      address_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask wmask_q;

    logic i_req;
    logic d_req;
    logic grant_d;
    logic grant_i;

    // D wins unless I is also waiting and D was served last.
    always_comb begin
        i_req   = bus.mem1_read;
        d_req   = bus.mem2_read | bus.mem2_write;
        grant_d = (state == arb_idle) && d_req && (!i_req || !last_d);
        grant_i = (state == arb_idle) && !grant_d && i_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= arb_idle;
            last_d  <= 1'b0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            case (state)
                arb_idle: begin
                    if (grant_d) begin
                        state   <= arb_serve_d;
                        write_q <= bus.mem2_write;
                        read_q  <= !bus.mem2_write;
                    end else if (grant_i) begin
                        state   <= arb_serve_i;
                        write_q <= 1'b0;
                        read_q  <= 1'b1;
                    end
                end
                arb_serve_i: begin
                    if (bus.pmem_resp) begin
                        state   <= arb_idle;
                        last_d  <= 1'b0;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                arb_serve_d: begin
                    if (bus.pmem_resp) begin
                        state   <= arb_idle;
                        last_d  <= 1'b1;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= arb_idle;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    // Holding registers keep memory-side values stable while the initiator inputs move.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_q <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else if (grant_d) begin
            address_q <= bus.mem2_address;
            wdata_q   <= bus.mem2_wdata;
            wmask_q   <= bus.mem2_wmask;
        end else if (grant_i) begin
            address_q <= bus.mem1_address;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end
    end

    assign bus.pmem_read    = read_q;
    assign bus.pmem_write   = write_q;
    assign bus.pmem_address = address_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_wmask   = wmask_q;

    assign bus.mem1_resp  = (state == arb_serve_i) && bus.pmem_resp;
    assign bus.mem2_resp  = (state == arb_serve_d) && bus.pmem_resp;
    assign bus.mem1_rdata = bus.pmem_rdata;
    assign bus.mem2_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem1_read    = 1'b0;
        bus.mem2_read    = 1'b0;
        bus.mem2_write   = 1'b0;
        bus.pmem_resp    = 1'b0;
    endtask

    task automatic check_strobes(input string tag, input logic rd, input logic wr);
        check({tag, " pmem_read"},  {15'd0, bus.pmem_read},  {15'd0, rd});
        check({tag, " pmem_write"}, {15'd0, bus.pmem_write}, {15'd0, wr});
    endtask

    task automatic check_resps(input string tag, input logic r1, input logic r2);
        check({tag, " mem1_resp"}, {15'd0, bus.mem1_resp}, {15'd0, r1});
        check({tag, " mem2_resp"}, {15'd0, bus.mem2_resp}, {15'd0, r2});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        bus.mem1_address = 16'h0000;
        bus.mem2_address = 16'h0000;
        bus.mem2_wdata   = 16'h0000;
        bus.mem2_wmask   = 2'b00;
        bus.pmem_rdata   = 16'h0000;

        repeat (2) @(negedge clk);
        check_strobes("reset", 1'b0, 1'b0);
        check("reset pmem_address", bus.pmem_address, 16'h0000);
        check("reset pmem_wdata", bus.pmem_wdata, 16'h0000);
        check("reset pmem_wmask", {14'd0, bus.pmem_wmask}, 16'h0000);
        check_resps("reset", 1'b0, 1'b0);
        reset = 1'b0;

        // pmem_resp while idle must not reach either initiator.
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        check_resps("idle resp", 1'b0, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_strobes("idle resp after", 1'b0, 1'b0);

        // Fetch only, memory answers in the third service cycle.
        bus.mem1_read    = 1'b1;
        bus.mem1_address = 16'h0040;
        @(negedge clk);
        bus.mem1_read = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check_strobes($sformatf("fetch c%0d", c), 1'b1, 1'b0);
            check($sformatf("fetch c%0d addr", c), bus.pmem_address, 16'h0040);
            check_resps($sformatf("fetch c%0d", c), 1'b0, 1'b0);
            if (c < 2) @(negedge clk);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1234;
        #1;
        check_resps("fetch done", 1'b1, 1'b0);
        check("fetch rdata", bus.mem1_rdata, 16'h1234);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_resps("fetch after", 1'b0, 1'b0);
        check_strobes("fetch after", 1'b0, 1'b0);

        // Contention with both held: D, I, D, I with one idle cycle between.
        bus.mem1_read    = 1'b1;
        bus.mem1_address = 16'h0010;
        bus.mem2_read    = 1'b1;
        bus.mem2_address = 16'h0020;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_strobes($sformatf("cont%0d", k), 1'b1, 1'b0);
            check($sformatf("cont%0d addr", k), bus.pmem_address,
                  (k % 2 == 0) ? 16'h0020 : 16'h0010);
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = 16'hA000 + 16'(k);
            #1;
            check_resps($sformatf("cont%0d", k), (k % 2 == 1), (k % 2 == 0));
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (k == 3) begin
                bus.mem1_read = 1'b0;
                bus.mem2_read = 1'b0;
            end
            check_strobes($sformatf("cont%0d gap", k), 1'b0, 1'b0);
        end

        // Write, with the initiator address changing mid-service.
        bus.mem2_write   = 1'b1;
        bus.mem2_address = 16'h0100;
        bus.mem2_wdata   = 16'hBEEF;
        bus.mem2_wmask   = 2'b01;
        @(negedge clk);
        bus.mem2_write   = 1'b0;
        bus.mem2_address = 16'h0200;
        check_strobes("write", 1'b0, 1'b1);
        check("write addr", bus.pmem_address, 16'h0100);
        check("write wdata", bus.pmem_wdata, 16'hBEEF);
        check("write wmask", {14'd0, bus.pmem_wmask}, 16'h0001);
        @(negedge clk);
        check("write addr held", bus.pmem_address, 16'h0100);
        check_strobes("write held", 1'b0, 1'b1);
        bus.pmem_resp = 1'b1;
        #1;
        check_resps("write done", 1'b0, 1'b1);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_strobes("write after", 1'b0, 1'b0);

        // Read and write together is handled as a write.
        bus.mem2_read    = 1'b1;
        bus.mem2_write   = 1'b1;
        bus.mem2_address = 16'h0400;
        @(negedge clk);
        bus.mem2_read  = 1'b0;
        bus.mem2_write = 1'b0;
        check_strobes("illegal", 1'b0, 1'b1);
        check("illegal addr", bus.pmem_address, 16'h0400);
        bus.pmem_resp = 1'b1;
        #1;
        check_resps("illegal done", 1'b0, 1'b1);
        @(negedge clk);
        bus.pmem_resp = 1'b0;

        // Asynchronous reset during a fetch.
        bus.mem1_read    = 1'b1;
        bus.mem1_address = 16'h0300;
        @(negedge clk);
        check_strobes("rst pre", 1'b1, 1'b0);
        #2;
        reset         = 1'b1;
        bus.pmem_resp = 1'b1;
        #1;
        check_strobes("rst async", 1'b0, 1'b0);
        check_resps("rst async", 1'b0, 1'b0);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        reset         = 1'b0;
        @(negedge clk);
        bus.mem1_read = 1'b0;
        check_strobes("rst reserve", 1'b1, 1'b0);
        check("rst reserve addr", bus.pmem_address, 16'h0300);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h5A5A;
        #1;
        check_resps("rst reserve done", 1'b1, 1'b0);
        check("rst reserve rdata", bus.mem1_rdata, 16'h5A5A);
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        check_strobes("rst reserve after", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
